// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state enum and the {pc, instr} buffer entry layout.
`timescale 1ns/1ps
package fetch_pkg;

    localparam int ADDR_W      = 64;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FULL = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} fetch entries.
// Ports: push/push_data in, pop in, flush in, head/full/empty out.
`timescale 1ns/1ps
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    fetch_entry_t  mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same edge, so a full
    // buffer may still accept a push alongside it.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(do_push)
                          - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetch FSM: drives IMem from the fetch PC, waits WAIT_CYCLES, buffers
// {pc,instr} for decode (InstrValid/InstrReady); Redirect flushes.
`timescale 1ns/1ps
module instr_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          DEPTH       = 2
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Enable,
    output logic [ADDR_W-1:0]  IMemAddress,
    input  logic [INSTR_W-1:0] IMemData,
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPC,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  RedirectPC,
    output logic               Busy
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              busy_q, busy_d;

    logic         push, flush, pop;
    logic         full, empty;
    fetch_entry_t head, push_data;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = &{1'b0, RedirectPC[1:0]};

    assign pop       = ~empty & InstrReady;
    assign push_data = '{pc: pc_q, instr: IMemData};

    assign IMemAddress = pc_q;
    assign InstrValid  = ~empty;
    assign Instr       = empty ? '0 : head.instr;
    assign InstrPC     = empty ? '0 : head.pc;
    assign Busy        = busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (Redirect) begin
            flush   = 1'b1;
            pc_d    = {RedirectPC[ADDR_W-1:2], 2'b00};
            cnt_d   = RELOAD;
            state_d = Enable ? WAIT : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Enable) begin
                        state_d = WAIT;
                        cnt_d   = RELOAD;
                    end
                end
                WAIT: begin
                    if (!Enable) begin
                        state_d = IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (!full || pop) begin
                        push  = 1'b1;
                        pc_d  = pc_q + ADDR_W'(INSTR_BYTES);
                        cnt_d = RELOAD;
                    end else begin
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (!Enable) begin
                        state_d = IDLE;
                    end else if (pop) begin
                        push    = 1'b1;
                        pc_d    = pc_q + ADDR_W'(INSTR_BYTES);
                        cnt_d   = RELOAD;
                        state_d = WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            busy_q  <= busy_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .Reset     (Reset),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer (WAIT_CYCLES=2, DEPTH=2).
// Inputs driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_instr_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Enable;
    logic [63:0] IMemAddress;
    logic [31:0] IMemData;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [63:0] InstrPC;
    logic        Redirect;
    logic [63:0] RedirectPC;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    instr_fetch_sequencer #(
        .WAIT_CYCLES (2),
        .RESET_PC    (64'h0),
        .DEPTH       (2)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Enable      (Enable),
        .IMemAddress (IMemAddress),
        .IMemData    (IMemData),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .Instr       (Instr),
        .InstrPC     (InstrPC),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .Busy        (Busy)
    );

    function automatic logic [31:0] rom(input logic [63:0] a);
        case (a)
            64'h00:  return 32'hF84003E9;
            64'h04:  return 32'hF84083EA;
            64'h08:  return 32'hF84103EB;
            64'h10:  return 32'hF84203ED;
            64'h28:  return 32'h17FFFFFD;
            64'h2C:  return 32'hF80203ED;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    always_comb IMemData = rom(IMemAddress);

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_head(input string tag,
                            input logic [63:0] pc,
                            input logic [31:0] ins);
        chk({tag, "_v"}, 64'(InstrValid), 64'd1);
        chk({tag, "_pc"}, InstrPC, pc);
        chk({tag, "_in"}, 64'(Instr), 64'(ins));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        Reset      = 1'b1;
        Enable     = 1'b0;
        InstrReady = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = '0;
        tick(1);
        Reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset      = 1'b1;
        Enable     = 1'b0;
        InstrReady = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = '0;
        #1;
        chk("rst_addr", IMemAddress, 64'h0);
        chk("rst_v", 64'(InstrValid), 64'd0);
        chk("rst_in", 64'(Instr), 64'd0);
        chk("rst_pc", InstrPC, 64'h0);
        chk("rst_busy", 64'(Busy), 64'd0);
        tick(1);
        Reset = 1'b0;

        // steady fetch
        Enable = 1'b1;
        InstrReady = 1'b1;
        tick(1);
        chk("st_busy", 64'(Busy), 64'd1);
        chk("st_v0", 64'(InstrValid), 64'd0);
        chk("st_a0", IMemAddress, 64'h0);
        tick(1);
        chk("st_v1", 64'(InstrValid), 64'd0);
        tick(1);
        chk_head("st_h0", 64'h0, 32'hF84003E9);
        chk("st_a4", IMemAddress, 64'h4);
        tick(1);
        chk("st_v3", 64'(InstrValid), 64'd0);
        chk("st_a4b", IMemAddress, 64'h4);
        tick(1);
        chk_head("st_h4", 64'h4, 32'hF84083EA);
        chk("st_a8", IMemAddress, 64'h8);
        tick(1);
        chk("st_v5", 64'(InstrValid), 64'd0);
        tick(1);
        chk_head("st_h8", 64'h8, 32'hF84103EB);
        chk("st_aC", IMemAddress, 64'hC);

        // backpressure
        do_reset();
        Enable = 1'b1;
        tick(7);
        chk("bp_a8", IMemAddress, 64'h8);
        chk("bp_busy", 64'(Busy), 64'd1);
        chk_head("bp_h0", 64'h0, 32'hF84003E9);
        tick(1);
        chk("bp_a8b", IMemAddress, 64'h8);
        chk_head("bp_h0b", 64'h0, 32'hF84003E9);
        InstrReady = 1'b1;
        tick(1);
        chk_head("bp_h4", 64'h4, 32'hF84083EA);
        chk("bp_aC", IMemAddress, 64'hC);
        tick(1);
        chk_head("bp_h8", 64'h8, 32'hF84103EB);
        tick(1);
        chk_head("bp_hC", 64'hC, 32'hC0DE000C);

        // redirect with two entries buffered
        do_reset();
        Enable = 1'b1;
        tick(5);
        chk_head("rd_pre", 64'h0, 32'hF84003E9);
        chk("rd_pre_a", IMemAddress, 64'h8);
        Redirect = 1'b1;
        RedirectPC = 64'h28;
        tick(1);
        Redirect = 1'b0;
        chk("rd_v", 64'(InstrValid), 64'd0);
        chk("rd_a", IMemAddress, 64'h28);
        chk("rd_pc0", InstrPC, 64'h0);
        chk("rd_in0", 64'(Instr), 64'd0);
        InstrReady = 1'b1;
        tick(1);
        chk("rd_v6", 64'(InstrValid), 64'd0);
        tick(1);
        chk_head("rd_h28", 64'h28, 32'h17FFFFFD);
        chk("rd_a2C", IMemAddress, 64'h2C);
        tick(2);
        chk_head("rd_h2C", 64'h2C, 32'hF80203ED);

        // misaligned redirect target
        do_reset();
        Enable = 1'b1;
        InstrReady = 1'b1;
        Redirect = 1'b1;
        RedirectPC = 64'h2B;
        tick(1);
        Redirect = 1'b0;
        chk("ma_a", IMemAddress, 64'h28);
        chk("ma_busy", 64'(Busy), 64'd1);
        tick(2);
        chk_head("ma_h", 64'h28, 32'h17FFFFFD);

        // async reset mid-WAIT
        do_reset();
        Enable = 1'b1;
        InstrReady = 1'b1;
        tick(11);
        chk("ar_a14", IMemAddress, 64'h14);
        chk("ar_busy1", 64'(Busy), 64'd1);
        chk_head("ar_h10", 64'h10, 32'hF84203ED);
        #2;
        Reset = 1'b1;
        #1;
        chk("ar_a", IMemAddress, 64'h0);
        chk("ar_v", 64'(InstrValid), 64'd0);
        chk("ar_busy", 64'(Busy), 64'd0);
        chk("ar_in", 64'(Instr), 64'd0);
        tick(1);
        Reset = 1'b0;
        Enable = 1'b0;

        // enable dropped in WAIT at PC 0x10
        do_reset();
        Enable = 1'b1;
        Redirect = 1'b1;
        RedirectPC = 64'h8;
        tick(1);
        Redirect = 1'b0;
        tick(4);
        chk("en_a10", IMemAddress, 64'h10);
        chk_head("en_h8", 64'h8, 32'hF84103EB);
        Enable = 1'b0;
        tick(1);
        chk("en_busy0", 64'(Busy), 64'd0);
        chk("en_a10b", IMemAddress, 64'h10);
        chk_head("en_h8b", 64'h8, 32'hF84103EB);
        InstrReady = 1'b1;
        tick(1);
        chk_head("en_hC", 64'hC, 32'hC0DE000C);
        tick(1);
        chk("en_v0", 64'(InstrValid), 64'd0);
        chk("en_a10c", IMemAddress, 64'h10);
        Enable = 1'b1;
        tick(1);
        chk("en_busy1", 64'(Busy), 64'd1);
        chk("en_v1", 64'(InstrValid), 64'd0);
        tick(1);
        chk("en_v2", 64'(InstrValid), 64'd0);
        tick(1);
        chk_head("en_h10", 64'h10, 32'hF84203ED);
        chk("en_a14", IMemAddress, 64'h14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_sequencer.md
# instr_fetch_sequencer

Fetch controller that sequences the read-only instruction memory. It drives the memory address from an internal fetch PC and waits a fixed number of cycles for read data to settle. It then captures each instruction word into a small prefetch buffer and hands {PC, instruction} pairs to decode over a valid/ready handshake. It sits between the instruction memory and the decode stage, and accepts branch redirects that flush in-flight fetches.

## Interface
- WAIT_CYCLES, 2: cycles from address launch to data capture; ≥1; WAIT_CYCLES × clock period must exceed the memory read delay.
- RESET_PC, 64'h0: fetch PC after reset.
- DEPTH, 2: prefetch buffer entries; power of 2, ≥2.
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Enable  in  1  fetch run enable.
- IMemAddress  out  64  address to instruction memory; equals the fetch PC.
- IMemData  in  32  instruction memory read data.
- InstrValid  out  1  buffer head valid.
- InstrReady  in  1  decode accepts the head.
- Instr  out  32  head instruction; 0 while InstrValid=0.
- InstrPC  out  64  head PC; 0 while InstrValid=0.
- Redirect  in  1  single-cycle branch redirect request.
- RedirectPC  in  64  redirect target; bits [1:0] are forced to 0.
- Busy  out  1  high when the state is not IDLE.

## Operation
- States are IDLE, WAIT and FULL.
- Reset values:
  - state IDLE; fetch PC = RESET_PC; wait counter 0; buffer empty.
  - IMemAddress=RESET_PC, InstrValid=0, Instr=0, InstrPC=0, Busy=0.
- IDLE:
  - Enable=1 → WAIT, counter loaded with WAIT_CYCLES-1.
  - The buffer continues to drain to decode.
- WAIT:
  - Counter >0: decrement.
  - Counter ==0 and buffer not full (after any same-cycle pop): push {fetch PC, IMemData}, fetch PC += 4, reload counter with WAIT_CYCLES-1, stay in WAIT.
  - Counter ==0 and buffer full: → FULL; fetch PC is held.
- FULL:
  - On the first edge where a pop occurs, push {fetch PC, IMemData} in the same edge, PC += 4, → WAIT with the counter reloaded.
- Enable=0 in WAIT or FULL → IDLE next edge.
  - The current fetch is abandoned; fetch PC and buffer contents are retained.
  - Re-enable restarts the full wait at the same PC.
- Pop: InstrValid & InstrReady at an edge removes the head.
- Redirect has highest priority.
  - At the edge: buffer emptied, fetch PC = {RedirectPC[63:2],2'b00}, counter = WAIT_CYCLES-1.
  - Next state is WAIT if Enable=1, otherwise IDLE.
  - A same-edge pop counts as a completed transfer; the pending push is discarded.
- Fetch PC is 64 bits and wraps modulo 2^64. No misalignment or X checking is done.

## Timing
- First-fetch latency:
  - Enable sampled at edge 0 → capture at edge WAIT_CYCLES.
  - InstrValid is high in the cycle after that edge.
- Steady-state throughput with InstrReady=1 is one instruction per WAIT_CYCLES cycles.
- IMemAddress changes only on the edge after a push, a redirect, or reset. It is stable for the whole wait window.
- Redirect → IMemAddress = target and InstrValid=0 in the next cycle; first target instruction is valid WAIT_CYCLES edges later.
- Instr and InstrPC are registered buffer outputs with no combinational path from IMemData.
- Backpressure: InstrReady only affects capture timing (the FULL state). Captured instructions are never dropped or duplicated.
- Reset asserted at any time, including mid-WAIT, forces all reset values immediately without a clock edge. Deassertion is synchronous to CLK.

## Structure
- Package fetch_pkg holds:
  - state enum {IDLE, WAIT, FULL}
  - INSTR_BYTES = 4
  - ADDR_W = 64, INSTR_W = 32
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of {pc, instr}.
  - Push/pop ports, full/empty flags, synchronous flush.
  - Simultaneous push and pop is allowed when full.
- The top level holds the FSM, wait counter and fetch PC.

## Test plan
- Steady fetch (WAIT_CYCLES=2, InstrReady=1, Enable=1 after reset):
  - Response: InstrPC/Instr = 0x0/F84003E9, 0x4/F84083EA, 0x8/F84103EB, one every 2 cycles.
  - IMemAddress steps 0→4→8→C.
- Backpressure (InstrReady=0):
  - Buffer fills with 0x0 and 0x4; state FULL; IMemAddress holds 0x8.
  - Raise InstrReady → 0x0, 0x4, then 0x8/F84103EB, with none missing or repeated.
- Redirect to 0x28 with 2 entries buffered:
  - InstrValid=0 and IMemAddress=0x28 the next cycle.
  - Then 0x28/17FFFFFD, followed by 0x2C/F80203ED.
- Redirect with RedirectPC=0x2B → IMemAddress=0x28 and InstrPC=0x28.
- Async reset pulsed between edges during WAIT at PC 0x14 → IMemAddress=0, InstrValid=0, Busy=0 before the next edge.
- Enable dropped in WAIT at PC 0x10:
  - IDLE; buffered entries still drain.
  - Re-enable → 0x10/F84203ED appears WAIT_CYCLES edges later.
